// File: rtl/ifid_lmsm_sequencer_pkg.sv
// Shared constants and types for the IF/ID stage and its LM/SM expander.
package ifid_lmsm_sequencer_pkg;

    localparam int unsigned DATA_W = 16;

    localparam logic [3:0] OP_LM  = 4'b0110;
    localparam logic [3:0] OP_SM  = 4'b0111;
    localparam logic [3:0] OP_NOP = 4'b1111;

    // Bubble: unused opcode, decode performs no register or memory write.
    localparam logic [15:0] NOP_INSTR = {OP_NOP, 12'h000};

    // PASS: normal pipeline register. SEQ: issuing the remaining LM/SM registers.
    typedef enum logic {
        PASS = 1'b0,
        SEQ  = 1'b1
    } state_t;

    // LM and SM differ only in opcode bit 0, so both match on the top three bits.
    function automatic logic is_lmsm_op(input logic [3:0] op);
        return (op[3:1] == OP_LM[3:1]) && (OP_SM[3:1] == OP_LM[3:1]);
    endfunction

endpackage

// File: rtl/ifid_lmsm_sequencer_lsb_clear.sv
// Clears the lowest set bit of an 8-bit register mask and flags mask shapes.
module lsb_clear_8 (
    input  logic [7:0] i_mask,
    output logic [7:0] o_cleared,
    output logic       o_multi_bit,
    output logic       o_zero
);

    // x & (x-1) drops the lowest set bit; a non-zero result means >= 2 bits were set.
    always_comb begin
        o_cleared   = i_mask & (i_mask - 8'd1);
        o_multi_bit = (o_cleared != 8'd0);
        o_zero      = (i_mask == 8'd0);
    end

endmodule

// File: rtl/ifid_lmsm_sequencer.sv
// IF/ID pipeline register that expands LM/SM into one issue per selected register.
// Handshake: there is no ready/valid pair towards fetch; fetch advances its PC on
// every edge where pc_hold is low, and valid_out marks ir_out as a real instruction.
module ifid_lmsm_sequencer
    import ifid_lmsm_sequencer_pkg::*;
#(
    parameter int unsigned        P_DATA_W    = DATA_W,
    parameter logic [P_DATA_W-1:0] P_NOP_INSTR = P_DATA_W'(NOP_INSTR)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [P_DATA_W-1:0] fetch_ir,
    input  logic [P_DATA_W-1:0] fetch_pc,
    input  logic                fetch_valid,
    input  logic                stall,
    input  logic                flush,
    output logic [P_DATA_W-1:0] ir_out,
    output logic [P_DATA_W-1:0] pc_out,
    output logic                valid_out,
    output logic                pc_hold,
    output logic [2:0]          lmsm_offset,
    output logic                seq_busy
);

    state_t              r_state;
    logic [P_DATA_W-1:0] r_ir;
    logic [P_DATA_W-1:0] r_pc;
    logic                r_valid;
    logic [2:0]          r_offset;

    state_t              w_state_nxt;
    logic [P_DATA_W-1:0] w_ir_nxt;
    logic [P_DATA_W-1:0] w_pc_nxt;
    logic                w_valid_nxt;
    logic [2:0]          w_offset_nxt;

    logic [7:0]          w_mask_cleared;
    logic                w_mask_multi;
    logic                w_mask_zero;
    logic                w_is_lmsm;
    logic                w_multi;
    logic                w_fetch_empty_lmsm;

    lsb_clear_8 u_lsb_clear (
        .i_mask      (r_ir[7:0]),
        .o_cleared   (w_mask_cleared),
        .o_multi_bit (w_mask_multi),
        .o_zero      (w_mask_zero)
    );

    // Decode-side view of the held instruction: more than one register still to issue.
    always_comb begin
        w_is_lmsm          = is_lmsm_op(r_ir[15:12]);
        w_multi            = w_is_lmsm && r_valid && !w_mask_zero && w_mask_multi;
        w_fetch_empty_lmsm = is_lmsm_op(fetch_ir[15:12]) && (fetch_ir[7:0] == 8'd0);
    end

    // Next-state and next-register selection: flush > stall > sequence advance > load.
    always_comb begin
        w_state_nxt  = r_state;
        w_ir_nxt     = r_ir;
        w_pc_nxt     = r_pc;
        w_valid_nxt  = r_valid;
        w_offset_nxt = r_offset;

        if (flush) begin
            w_state_nxt  = PASS;
            w_ir_nxt     = P_NOP_INSTR;
            w_valid_nxt  = 1'b0;
            w_offset_nxt = 3'd0;
        end else if (stall) begin
            // hold everything
        end else if (w_multi) begin
            // Bit 8 and the opcode/register fields ride along unchanged.
            w_state_nxt  = SEQ;
            w_ir_nxt     = {r_ir[P_DATA_W-1:8], w_mask_cleared};
            w_offset_nxt = r_offset + 3'd1;
        end else begin
            w_state_nxt  = PASS;
            w_pc_nxt     = fetch_pc;
            w_offset_nxt = 3'd0;
            if (w_fetch_empty_lmsm) begin
                // An LM/SM that selects no register does nothing; issue a bubble.
                w_ir_nxt    = P_NOP_INSTR;
                w_valid_nxt = 1'b0;
            end else begin
                w_ir_nxt    = fetch_ir;
                w_valid_nxt = fetch_valid;
            end
        end
    end

    // State and pipeline registers; reset abandons any partial LM/SM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= PASS;
            r_ir     <= P_NOP_INSTR;
            r_pc     <= '0;
            r_valid  <= 1'b0;
            r_offset <= 3'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_ir     <= w_ir_nxt;
            r_pc     <= w_pc_nxt;
            r_valid  <= w_valid_nxt;
            r_offset <= w_offset_nxt;
        end
    end

    // pc_hold is combinational so fetch freezes in the same cycle the condition appears.
    always_comb begin
        ir_out      = r_ir;
        pc_out      = r_pc;
        valid_out   = r_valid;
        lmsm_offset = r_offset;
        seq_busy    = (r_state == SEQ);
        pc_hold     = stall || w_multi;
    end

endmodule

// File: tb/tb_ifid_lmsm_sequencer.sv
// Directed bench for the IF/ID LM/SM sequencer: vector table plus multi-cycle sequences.
module tb_ifid_lmsm_sequencer;

    logic        clk;
    logic        rst_n;
    logic [15:0] fetch_ir;
    logic [15:0] fetch_pc;
    logic        fetch_valid;
    logic        stall;
    logic        flush;
    logic [15:0] ir_out;
    logic [15:0] pc_out;
    logic        valid_out;
    logic        pc_hold;
    logic [2:0]  lmsm_offset;
    logic        seq_busy;

    int total;
    int bad;

    typedef struct {
        logic [15:0] f_ir;
        logic [15:0] f_pc;
        logic        f_valid;
        logic [15:0] e_ir;
        logic [15:0] e_pc;
        logic        e_valid;
        logic        e_hold;
    } vec_t;

    vec_t vecs[6];

    ifid_lmsm_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_ir    (fetch_ir),
        .fetch_pc    (fetch_pc),
        .fetch_valid (fetch_valid),
        .stall       (stall),
        .flush       (flush),
        .ir_out      (ir_out),
        .pc_out      (pc_out),
        .valid_out   (valid_out),
        .pc_hold     (pc_hold),
        .lmsm_offset (lmsm_offset),
        .seq_busy    (seq_busy)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [15:0] e_ir, input logic [15:0] e_pc,
                             input logic e_valid, input logic e_hold, input logic [2:0] e_off,
                             input logic e_busy);
        check({tag, ".ir"},    32'(ir_out),      32'(e_ir));
        check({tag, ".pc"},    32'(pc_out),      32'(e_pc));
        check({tag, ".valid"}, 32'(valid_out),   32'(e_valid));
        check({tag, ".hold"},  32'(pc_hold),     32'(e_hold));
        check({tag, ".off"},   32'(lmsm_offset), 32'(e_off));
        check({tag, ".busy"},  32'(seq_busy),    32'(e_busy));
    endtask

    task automatic set_fetch(input logic [15:0] ir, input logic [15:0] pc, input logic v);
        fetch_ir    = ir;
        fetch_pc    = pc;
        fetch_valid = v;
    endtask

    logic [7:0] lm_masks[4];
    logic [7:0] m;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        set_fetch(16'h0000, 16'h0000, 1'b0);

        // single-cycle vectors: all loaded in PASS, none with >= 2 mask bits under LM/SM
        vecs[0] = '{16'h0298, 16'h0010, 1'b1, 16'h0298, 16'h0010, 1'b1, 1'b0}; // ADD passthrough
        vecs[1] = '{16'h1234, 16'h0012, 1'b0, 16'h1234, 16'h0012, 1'b0, 1'b0}; // bubble keeps ir
        vecs[2] = '{16'h6100, 16'h0014, 1'b1, 16'hF000, 16'h0014, 1'b0, 1'b0}; // LM empty mask
        vecs[3] = '{16'h7010, 16'h0016, 1'b1, 16'h7010, 16'h0016, 1'b1, 1'b0}; // SM one bit
        vecs[4] = '{16'h40FF, 16'h0018, 1'b1, 16'h40FF, 16'h0018, 1'b1, 1'b0}; // LW, not LM/SM
        vecs[5] = '{16'h7000, 16'h001A, 1'b1, 16'hF000, 16'h001A, 1'b0, 1'b0}; // SM empty mask

        lm_masks[0] = 8'hA5;
        lm_masks[1] = 8'hA4;
        lm_masks[2] = 8'hA0;
        lm_masks[3] = 8'h80;

        // reset values while held in reset
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 16'hF000, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
        rst_n = 1'b1;

        // table
        for (int i = 0; i < 6; i++) begin
            set_fetch(vecs[i].f_ir, vecs[i].f_pc, vecs[i].f_valid);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_pc, vecs[i].e_valid,
                      vecs[i].e_hold, 3'd0, 1'b0);
        end

        // asynchronous reset mid-clock
        set_fetch(16'h0298, 16'h0010, 1'b1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 16'hF000, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // LM 62A5: four issues, then the next fetch
        set_fetch(16'h62A5, 16'h0020, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) set_fetch(16'h0298, 16'h0022, 1'b1);
            check_all($sformatf("lm%0d", i), {8'h62, lm_masks[i]}, 16'h0020, 1'b1,
                      (i < 3), 3'(i), (i > 0));
        end
        tick();
        check_all("lm_next", 16'h0298, 16'h0022, 1'b1, 1'b0, 3'd0, 1'b0);

        // SM 7E06 stalled on its second issue
        set_fetch(16'h7E06, 16'h0030, 1'b1);
        tick();
        set_fetch(16'h0298, 16'h0032, 1'b1);
        check_all("sm0", 16'h7E06, 16'h0030, 1'b1, 1'b1, 3'd0, 1'b0);
        tick();
        check_all("sm1", 16'h7E04, 16'h0030, 1'b1, 1'b0, 3'd1, 1'b1);
        stall = 1'b1;
        #1;
        check("stall_hold_comb", 32'(pc_hold), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all($sformatf("sm_stall%0d", i), 16'h7E04, 16'h0030, 1'b1, 1'b1, 3'd1, 1'b1);
        end
        stall = 1'b0;
        #1;
        check("stall_release_hold", 32'(pc_hold), 32'd0);
        tick();
        check_all("sm_next", 16'h0298, 16'h0032, 1'b1, 1'b0, 3'd0, 1'b0);

        // flush during second issue of LM 60FF, alone and together with stall
        for (int k = 0; k < 2; k++) begin
            set_fetch(16'h60FF, 16'h0040, 1'b1);
            tick();
            set_fetch(16'h0298, 16'h0042, 1'b1);
            tick();
            check_all($sformatf("fl%0d_pre", k), 16'h60FE, 16'h0040, 1'b1, 1'b1, 3'd1, 1'b1);
            flush = 1'b1;
            stall = (k == 1);
            tick();
            check_all($sformatf("fl%0d", k), 16'hF000, 16'h0040, 1'b0, (k == 1), 3'd0, 1'b0);
            flush = 1'b0;
            stall = 1'b0;
            tick();
            check_all($sformatf("fl%0d_next", k), 16'h0298, 16'h0042, 1'b1, 1'b0, 3'd0, 1'b0);
        end

        // full mask: eight issues, offset reaches 7
        set_fetch(16'h60FF, 16'h0050, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) set_fetch(16'h0298, 16'h0052, 1'b1);
            m = 8'hFF << i;
            check_all($sformatf("ff%0d", i), {8'h60, m}, 16'h0050, 1'b1, (i < 7), 3'(i), (i > 0));
        end
        tick();
        check_all("ff_next", 16'h0298, 16'h0052, 1'b1, 1'b0, 3'd0, 1'b0);

        // reset in the middle of a sequence
        set_fetch(16'h62A5, 16'h0060, 1'b1);
        tick();
        tick();
        check_all("mid_pre", 16'h62A4, 16'h0060, 1'b1, 1'b1, 3'd1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("mid_rst", 16'hF000, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifid_lmsm_sequencer.md
Name: ifid_lmsm_sequencer

Overview:
IF/ID pipeline register between fetch and decode. It registers the fetched instruction and PC and drives them as the decoder's IR and fromPipe1PC.
It expands LM/SM (opcodes 0110/0111) into one issued instruction per selected register. Each issue clears the lowest set bit of IR[7:0], so decode's priority encoder selects the next register.
It holds fetch while a multi-register sequence is in progress. Stall and flush come from the hazard/branch logic.

Parameters:
DATA_W, 16, instruction and PC width
NOP_INSTR, 16'hF000, bubble encoding (unused opcode 1111; decode default case: no reg/mem write)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetch_ir  in  DATA_W  instruction from fetch
fetch_pc  in  DATA_W  PC of fetch_ir
fetch_valid  in  1  fetch_ir/fetch_pc are valid
stall  in  1  hazard unit: hold all outputs and state
flush  in  1  squash held instruction (taken branch/JAL/JLR/R7 write)
ir_out  out  DATA_W  instruction to decode (IR)
pc_out  out  DATA_W  PC to decode (fromPipe1PC)
valid_out  out  1  ir_out is a real instruction
pc_hold  out  1  fetch must not advance PC next edge
lmsm_offset  out  3  number of registers already issued in current LM/SM (0 on first issue)
seq_busy  out  1  FSM in SEQ

Behaviour:
- Async reset (rst_n=0): ir_out=NOP_INSTR, pc_out=0, valid_out=0, lmsm_offset=0, state=PASS. Combinational outputs follow: pc_hold=0, seq_busy=0.
- is_lmsm = ir_out[15:13]==3'b011. mask = ir_out[7:0]; ir_out[8] is ignored and carried unchanged.
- multi = is_lmsm && popcount(mask)>=2 && valid_out (combinational).
- pc_hold = stall || multi. It is combinational, so fetch sees it in the same cycle.
- seq_busy = (state==SEQ).
- Priority per edge: flush > stall > SEQ advance > PASS load.
- flush=1: ir_out=NOP_INSTR, valid_out=0, lmsm_offset=0, state=PASS, pc_out unchanged. flush overrides stall.
- stall=1 (no flush): every register holds.
- PASS, multi=0: load ir_out=fetch_ir, pc_out=fetch_pc, valid_out=fetch_valid, lmsm_offset=0. Latency 1 cycle.
  - On load, LM/SM with fetch_ir[7:0]==0 is replaced by NOP_INSTR with valid_out=0.
  - LM/SM with exactly one mask bit loads normally and issues in one cycle with no hold.
- PASS, multi=1 (LM/SM with ≥2 bits just loaded): state=SEQ. Clear the lowest set bit of ir_out[7:0] and increment lmsm_offset, both in the same edge. pc_out is unchanged.
- SEQ, multi=1: same clear-lowest-bit and increment.
- SEQ, multi=0: the last register is issuing this cycle. Next edge loads from fetch as in PASS and sets state=PASS.
- Result: an N-bit mask (N≥2) occupies N consecutive unstalled cycles; pc_hold is high for the first N-1.
- lmsm_offset maximum is 7 (mask 0xFF); no wrap is possible.
- fetch_valid=0 in PASS loads a bubble (valid_out=0; ir_out takes fetch_ir unchanged).
- Reset mid-sequence: immediate return to reset values; the partial LM/SM is abandoned.

Decomposition:
- Shared package: opcode constants (OP_LM=4'b0110, OP_SM=4'b0111, OP_NOP=4'b1111), NOP_INSTR, state enum {PASS, SEQ}.
- Sub-module lsb_clear_8 (combinational):
  - in[7:0] → out = in & (in-1)
  - multi_bit = (out != 0)
  - zero = (in == 0)
- The top level contains the FSM and registers.

Test Plan:
1. Reset: assert rst_n=0 mid-clock → ir_out=16'hF000, pc_out=0, valid_out=0, pc_hold=0 immediately (asynchronous).
2. Passthrough: fetch_ir=16'h0298 (ADD), fetch_pc=16'h0010, valid → next edge ir_out=16'h0298, pc_out=16'h0010, valid_out=1, pc_hold=0.
3. LM expansion: fetch_ir=16'h62A5, pc=16'h0020 → ir_out[7:0] sequence A5, A4, A0, 80 on four consecutive edges.
   - lmsm_offset 0,1,2,3.
   - pc_hold=1 during the first three issues, 0 on the fourth.
   - pc_out stays 16'h0020.
   - The fifth edge loads the next fetch_ir.
4. Stall mid-sequence: during SM 16'h7E06, stall=1 on the second issue for 3 cycles → ir_out[7:0]=04 and lmsm_offset=1 held all 3 cycles, pc_hold=1; the sequence resumes after stall drops.
5. Flush: flush=1 during the second issue of LM 16'h60FF → next edge ir_out=16'hF000, valid_out=0, seq_busy=0, lmsm_offset=0.
   - flush=1 and stall=1 together give the same result.
6. Masks: LM with mask 0x00 → ir_out=16'hF000, valid_out=0. SM 16'h7010 (single bit) → one issue, pc_hold=0, lmsm_offset=0.
